mem_access_unit: RTL

CPU-side initiator for the word-addressed data memory. It accepts one load or store request at a time from the execute stage and turns byte or halfword accesses into word read and read-modify-write sequences. It sign- or zero-extends load data, flags misaligned or illegal accesses, and signals completion with a one-cycle `done` pulse. It sits between the datapath and the data memory, which has a combinational read port and a write port sampled on the clock edge.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_lane_mux.sv | 42 ++++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: op encodings,
// the FSM state type and the request legality checks used at acceptance.
// No ports; imported by mem_access_unit and lane_mux.
package mau_pkg;

  // Access type encodings; op[1:0] is the size, op[2] selects zero-extend on loads.
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Size 11 is never legal. A load with bit 2 set and word size (110) is
  // illegal; stores ignore bit 2, so 110 is a plain word store.
  function automatic logic op_illegal(input logic [2:0] op, input logic wr);
    return (op[1:0] == 2'b11) || (!wr && op[2] && op[1]);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return ((op[1:0] == 2'b01) && a[0]) ||
           ((op[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// Byte/halfword lane steering: extracts and extends load data from a memory
// word, and merges store data into the word read back for read-modify-write.
// Ports: op_i/lane_i select the access, rd_word_i is the memory word,
// wdata_i the store data; ld_data_o is the extended load, st_word_o the merge.
module lane_mux
  import mau_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    byte_v    = rd_word_i[{lane_i, 3'b000} +: 8];
    half_v    = rd_word_i[{lane_i[1], 4'b0000} +: 16];
    sext      = ~op_i[2];
    ld_data_o = rd_word_i;
    st_word_o = rd_word_i;
    case (op_i[1:0])
      2'b00: begin
        ld_data_o = {{24{sext & byte_v[7]}}, byte_v};
        st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      2'b01: begin
        ld_data_o = {{16{sext & half_v[15]}}, half_v};
        st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_data_o = rd_word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory: one request at a
// time, sub-word stores done as read-modify-write, loads extended, faults flagged.
// Ports: req/wr/op/addr/wdata request in; busy/done/fault/rdata status out;
// mem_addr/mem_we/mem_wdata drive memory, mem_rd is its combinational read data.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rd
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fault_q, fault_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         ld_data, st_word;
  logic                req_fault;

  // Address bits above the memory's word range are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  lane_mux u_lane_mux (
    .op_i      (op_q),
    .lane_i    (lane_q),
    .rd_word_i (mem_rd),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_fault   = op_illegal(op, wr) || misaligned(op, addr[1:0]);

    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d       = wr;
          op_d       = op;
          lane_d     = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = addr[ADDR_W+1:2];
          fault_d    = req_fault;
          state_d    = req_fault ? DONE : READ;
        end
      end
      READ: begin
        // Every store reads first, so word and sub-word stores share one latency.
        if (wr_q) begin
          mem_wdata_d = st_word;
          state_d     = WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Decoded from state so an asynchronous reset kills the write immediately.
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    fault  = (state_q == DONE) && fault_q;
    mem_we = (state_q == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
